// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared types and helpers for the multi-port register file:
//                sequencer state encoding and the write-port selector used by
//                the bypass path.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

  // Sequencer states: sweep-clear after reset, then normal operation.
  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  // Upper bounds for the selector; callers zero-pad their port vectors.
  localparam int unsigned MAX_PORTS = 16;
  localparam int unsigned MAX_AW    = 16;
  localparam int unsigned PSEL_W    = 4;

  typedef struct packed {
    logic              hit;
    logic [PSEL_W-1:0] idx;
  } port_sel_t;

  // Highest-index enabled write port whose address matches addr.
  // Later iterations overwrite earlier ones, so the top port wins.
  function automatic port_sel_t port_sel(
    input logic [MAX_PORTS-1:0]        en,
    input logic [MAX_PORTS*MAX_AW-1:0] addrs,
    input logic [MAX_AW-1:0]           addr
  );
    port_sel_t s;
    s = '0;
    for (int p = 0; p < MAX_PORTS; p++) begin
      if (en[p] && (addrs[p*MAX_AW +: MAX_AW] == addr)) begin
        s.hit = 1'b1;
        s.idx = PSEL_W'(p);
      end
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_clear_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_clear_fsm
//  Description : Post-reset sequencer. Sweeps every entry with a zero write,
//                one per cycle, then raises init_done and stays READY.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clock,
  input  logic          reset,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx,
  output logic          init_done
);

  // Counter carries one spare bit so the sweep end is unambiguous.
  localparam logic [AW:0] LAST_IDX = (AW+1)'(NREGS - 1);

  rf_state_t   state_q, state_d;
  logic [AW:0] clr_idx_q, clr_idx_d;
  logic        init_done_q, init_done_d;

  // Next-state: advance the sweep, hand over to READY after the last entry.
  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    init_done_d = init_done_q;
    case (state_q)
      RF_CLEAR: begin
        init_done_d = 1'b0;
        clr_idx_d   = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d     = RF_READY;
          init_done_d = 1'b1;
        end
      end
      RF_READY: begin
        init_done_d = 1'b1;
      end
      default: begin
        state_d     = RF_CLEAR;
        clr_idx_d   = '0;
        init_done_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset back to the start of the sweep.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RF_CLEAR;
      clr_idx_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      init_done_q <= init_done_d;
    end
  end

  assign busy      = (state_q == RF_CLEAR);
  assign clr_we    = busy && !reset;
  assign clr_idx   = clr_idx_q[AW-1:0];
  assign init_done = init_done_q;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Parametrised NRD-read / NWR-write integer register file with
//                write-through bypass, optional hardwired-zero entry 0,
//                highest-port-wins write merge and a registered collision flag.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN     = 64,
  parameter  int NREGS    = 32,
  parameter  int NRD      = 2,
  parameter  int NWR      = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                clock,
  input  logic                reset,
  output logic                init_done,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  output logic                wr_conflict
);

  logic          busy;
  logic          clr_we;
  logic [AW-1:0] clr_idx;
  logic          ready;

  regfile_clear_fsm #(.NREGS(NREGS)) u_clear_fsm (
    .clock     (clock),
    .reset     (reset),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_idx   (clr_idx),
    .init_done (init_done)
  );

  assign ready = !busy;

  logic [NWR-1:0]                wen_eff;
  logic [MAX_PORTS-1:0]          en_pad;
  logic [MAX_PORTS*MAX_AW-1:0]   addr_pad;

  // Qualified write enables: only in READY, not under reset, and never to a
  // hardwired-zero entry (such writes also stay out of collision detection).
  always_comb begin
    wen_eff  = '0;
    en_pad   = '0;
    addr_pad = '0;
    for (int p = 0; p < NWR; p++) begin
      wen_eff[p] = wr_en[p] && ready && !reset &&
                   !((ZERO_REG != 0) && (wr_addr[p*AW +: AW] == '0));
      en_pad[p]  = wen_eff[p];
      addr_pad[p*MAX_AW +: MAX_AW] = MAX_AW'(wr_addr[p*AW +: AW]);
    end
  end

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // Write merge: clear sweep owns the array while busy; otherwise ports are
  // applied in ascending order so the highest-index port lands last.
  always_comb begin
    regs_d = regs_q;
    if (clr_we) begin
      regs_d[clr_idx] = '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wen_eff[p]) begin
          regs_d[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Storage array; contents are defined by the post-reset sweep.
  always_ff @(posedge clock) begin
    regs_q <= regs_d;
  end

  logic wr_conflict_q, wr_conflict_d;

  // Any pair of qualified ports targeting the same entry this cycle.
  always_comb begin
    wr_conflict_d = 1'b0;
    for (int p = 0; p < NWR; p++) begin
      for (int q = p + 1; q < NWR; q++) begin
        if (wen_eff[p] && wen_eff[q] &&
            (wr_addr[p*AW +: AW] == wr_addr[q*AW +: AW])) begin
          wr_conflict_d = 1'b1;
        end
      end
    end
  end

  // One-cycle collision pulse, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_conflict_q <= 1'b0;
    end else begin
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign wr_conflict = wr_conflict_q;

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [AW-1:0]   ra;
    port_sel_t       sel;
    logic [XLEN-1:0] byp;
    logic [XLEN-1:0] rd_val;

    // Read path: zero while clearing, zero for entry 0, bypass, then storage.
    always_comb begin
      ra  = rd_addr[r*AW +: AW];
      sel = port_sel(en_pad, addr_pad, MAX_AW'(ra));
      byp = '0;
      for (int p = 0; p < NWR; p++) begin
        if (p == int'(sel.idx)) begin
          byp = wr_data[p*XLEN +: XLEN];
        end
      end
      if (!ready) begin
        rd_val = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_val = '0;
      end else if ((BYPASS != 0) && sel.hit) begin
        rd_val = byp;
      end else begin
        rd_val = regs_q[ra];
      end
    end

    assign rd_data[r*XLEN +: XLEN] = rd_val;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Self-checking bench for regfile_mp. Drives a bypassing and a
//                non-bypassing instance with the same stimulus and checks
//                both against a behavioural array model every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_mp;

  localparam int XLEN = 64;
  localparam int AW   = 5;
  localparam int NR   = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic [2*AW-1:0]   rd_addr;
  logic [1:0]        wr_en;
  logic [2*AW-1:0]   wr_addr;
  logic [2*XLEN-1:0] wr_data;

  logic [2*XLEN-1:0] rd_data_b, rd_data_n;
  logic              init_done_b, init_done_n;
  logic              wr_conflict_b, wr_conflict_n;

  int tests    = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  always #5 clock = ~clock;

  regfile_mp #(.XLEN(64), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)) u_dut_b (
    .clock(clock), .reset(reset), .init_done(init_done_b),
    .rd_addr(rd_addr), .rd_data(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_conflict(wr_conflict_b)
  );

  regfile_mp #(.XLEN(64), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(0)) u_dut_n (
    .clock(clock), .reset(reset), .init_done(init_done_n),
    .rd_addr(rd_addr), .rd_data(rd_data_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_conflict(wr_conflict_n)
  );

  // ---------------- behavioural model ----------------
  logic [XLEN-1:0] mem [NR];
  int              m_cnt  = 0;
  bit              m_done = 1'b0;
  bit              m_conf = 1'b0;

  always @(posedge clock) begin
    logic [AW-1:0] a0, a1;
    a0 = wr_addr[0 +: AW];
    a1 = wr_addr[AW +: AW];
    if (reset) begin
      m_cnt  = 0;
      m_done = 1'b0;
      m_conf = 1'b0;
    end else if (!m_done) begin
      mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == NR) m_done = 1'b1;
      m_conf = 1'b0;
    end else begin
      m_conf = (wr_en == 2'b11) && (a0 == a1) && (a0 != 0);
      if (wr_en[0] && a0 != 0) mem[a0] = wr_data[0 +: XLEN];
      if (wr_en[1] && a1 != 0) mem[a1] = wr_data[XLEN +: XLEN];
    end
  end

  function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a, input bit byp);
    logic [XLEN-1:0] v;
    if (!m_done) return '0;
    if (a == 0) return '0;
    v = mem[a];
    if (byp && !reset) begin
      if (wr_en[0] && wr_addr[0 +: AW] == a)  v = wr_data[0 +: XLEN];
      if (wr_en[1] && wr_addr[AW +: AW] == a) v = wr_data[XLEN +: XLEN];
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    if (chk_on) begin
      check("init_done_b", 64'(init_done_b), 64'(m_done));
      check("init_done_n", 64'(init_done_n), 64'(m_done));
      check("conflict_b", 64'(wr_conflict_b), 64'(m_conf));
      check("conflict_n", 64'(wr_conflict_n), 64'(m_conf));
      for (int r = 0; r < 2; r++) begin
        check("rd_b", rd_data_b[r*XLEN +: XLEN], exp_read(rd_addr[r*AW +: AW], 1'b1));
        check("rd_n", rd_data_n[r*XLEN +: XLEN], exp_read(rd_addr[r*AW +: AW], 1'b0));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en[p]                 = 1'b1;
    wr_addr[p*AW +: AW]      = a;
    wr_data[p*XLEN +: XLEN]  = d;
  endtask

  task automatic idle();
    wr_en = 2'b00;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    cyc();
    reset  = 1'b0;
    chk_on = 1'b1;

    // Sweep: writes offered throughout must be ignored.
    for (int i = 0; i < 31; i++) begin
      set_wr(0, 5'(i), 64'hBAD0 + 64'(i));
      set_wr(1, 5'(i + 1), 64'hC0DE);
      set_rd(0, 5'(i));
      set_rd(1, 5'(31 - i));
      #1;
      check("sweep_rd_zero", rd_data_b[0 +: XLEN], 64'h0);
      cyc();
    end
    idle();
    check("init_done_edge31", 64'(init_done_b), 64'h0);
    cyc();
    check("init_done_edge32", 64'(init_done_b), 64'h1);

    // Every entry reads zero after the sweep.
    for (int i = 0; i < 32; i += 2) begin
      set_rd(0, 5'(i));
      set_rd(1, 5'(i + 1));
      #1;
      check("post_clear_p0", rd_data_n[0 +: XLEN], 64'h0);
      check("post_clear_p1", rd_data_n[XLEN +: XLEN], 64'h0);
      cyc();
    end

    // Same-cycle write and read of entry 5.
    set_wr(0, 5'd5, 64'hDEAD_BEEF);
    set_rd(0, 5'd5);
    #1;
    check("bypass_same_cycle", rd_data_b[0 +: XLEN], 64'hDEAD_BEEF);
    check("nobypass_same_cycle", rd_data_n[0 +: XLEN], 64'h0);
    cyc();
    idle();
    #1;
    check("nobypass_next_cycle", rd_data_n[0 +: XLEN], 64'hDEAD_BEEF);

    // Both ports write entry 7: port 1 wins, collision pulse follows.
    set_wr(0, 5'd7, 64'h11);
    set_wr(1, 5'd7, 64'h22);
    set_rd(1, 5'd7);
    #1;
    check("bypass_priority", rd_data_b[XLEN +: XLEN], 64'h22);
    check("conflict_before", 64'(wr_conflict_b), 64'h0);
    cyc();
    idle();
    #1;
    check("conflict_pulse", 64'(wr_conflict_b), 64'h1);
    check("stored_priority", rd_data_n[XLEN +: XLEN], 64'h22);
    cyc();
    check("conflict_cleared", 64'(wr_conflict_b), 64'h0);

    // Both ports write entry 0: dropped, no collision.
    set_wr(0, 5'd0, 64'hAAAA);
    set_wr(1, 5'd0, 64'hBBBB);
    set_rd(0, 5'd0);
    #1;
    check("zero_same_cycle", rd_data_b[0 +: XLEN], 64'h0);
    cyc();
    idle();
    #1;
    check("zero_no_conflict", 64'(wr_conflict_b), 64'h0);
    check("zero_later", rd_data_b[0 +: XLEN], 64'h0);
    cyc();

    // Fill every entry with index*3, two entries per cycle.
    for (int i = 0; i < 32; i += 2) begin
      set_wr(0, 5'(i), 64'(i * 3));
      set_wr(1, 5'(i + 1), 64'((i + 1) * 3));
      cyc();
    end
    idle();
    for (int k = 0; k < 24; k++) begin
      set_rd(0, 5'($urandom_range(31)));
      set_rd(1, 5'($urandom_range(31)));
      cyc();
    end
    set_rd(0, 5'd10);
    set_rd(1, 5'd31);
    #1;
    check("fill_entry10", rd_data_n[0 +: XLEN], 64'd30);
    check("fill_entry31", rd_data_b[XLEN +: XLEN], 64'd93);

    // Reset from READY, then again mid-sweep at index 10, held two cycles.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 31; i++) cyc();
    check("restart_edge31", 64'(init_done_n), 64'h0);
    cyc();
    check("restart_edge32", 64'(init_done_n), 64'h1);
    set_rd(0, 5'd5);
    set_rd(1, 5'd31);
    #1;
    check("restart_entry5", rd_data_b[0 +: XLEN], 64'h0);
    check("restart_entry31", rd_data_n[XLEN +: XLEN], 64'h0);
    cyc();
    cyc();

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
`default_nettype wire
